// File: rtl/bullet_scheduler.sv
// Bullet spawn/lifetime scheduler for four bullet_sprite slots during the fight phase.
// Optional build macro BULLET_SCHED_LFSR_EN selects LFSR-based spawn_x instead of a fixed cycle.
module bullet_scheduler #(
  parameter int unsigned FIGHT_STATE    = 1,
  parameter int unsigned SPAWN_INTERVAL = 30,
  parameter int unsigned WAVE_FRAMES    = 600,
  parameter int unsigned LIFE_FRAMES    = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] state,
  input  logic       frame_tick,
  input  logic [3:0] hit,
  output logic [3:0] slot_active,
  output logic [3:0] spawn_strobe,
  output logic [9:0] spawn_x,
  output logic [9:0] spawn_y,
  output logic [1:0] spawn_xdir,
  output logic [3:0] hit_count,
  output logic       wave_done
);

  localparam int unsigned NSLOT = 4;
  localparam int unsigned AW    = 8;
  localparam int unsigned WW    = 10;
  localparam int unsigned TW    = 8;
  localparam int unsigned XW    = 10;
  // Age register reads 0 on the first tick after spawn, so the last live tick is LIFE_FRAMES-2.
  localparam int unsigned AGE_LAST = (LIFE_FRAMES > 2) ? LIFE_FRAMES - 2 : 0;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} fsm_t;

  fsm_t            fsm_q, fsm_d;
  logic [WW-1:0]   wave_cnt_q, wave_cnt_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [AW-1:0]   age_q [NSLOT];
  logic [AW-1:0]   age_d [NSLOT];
  logic [3:0]      slot_d, strobe_d, hit_cnt_d, hit_mask;
  logic [XW-1:0]   x_d, y_d;
  logic [1:0]      xdir_d;
  logic            done_d, xdir_pos_q, xdir_pos_d, free_found;
  logic [1:0]      free_idx;
  logic [2:0]      n_hits;
  logic [4:0]      hit_sum;
  logic            fight;
`ifdef BULLET_SCHED_LFSR_EN
  logic [7:0]      lfsr_q, lfsr_d;
`else
  logic [1:0]      x_idx_q, x_idx_d;
`endif

  assign fight = (state == 4'(FIGHT_STATE));

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q        <= IDLE;
      wave_cnt_q   <= '0;
      timer_q      <= '0;
      age_q        <= '{default: '0};
      slot_active  <= '0;
      spawn_strobe <= '0;
      spawn_x      <= '0;
      spawn_y      <= '0;
      spawn_xdir   <= '0;
      hit_count    <= '0;
      wave_done    <= 1'b0;
      xdir_pos_q   <= 1'b0;
`ifdef BULLET_SCHED_LFSR_EN
      lfsr_q       <= 8'hA5;
`else
      x_idx_q      <= '0;
`endif
    end else begin
      fsm_q        <= fsm_d;
      wave_cnt_q   <= wave_cnt_d;
      timer_q      <= timer_d;
      age_q        <= age_d;
      slot_active  <= slot_d;
      spawn_strobe <= strobe_d;
      spawn_x      <= x_d;
      spawn_y      <= y_d;
      spawn_xdir   <= xdir_d;
      hit_count    <= hit_cnt_d;
      wave_done    <= done_d;
      xdir_pos_q   <= xdir_pos_d;
`ifdef BULLET_SCHED_LFSR_EN
      lfsr_q       <= lfsr_d;
`else
      x_idx_q      <= x_idx_d;
`endif
    end
  end

  // Next-state, slot bookkeeping and spawn decision
  always_comb begin
    fsm_d      = fsm_q;
    wave_cnt_d = wave_cnt_q;
    timer_d    = timer_q;
    age_d      = age_q;
    slot_d     = slot_active;
    strobe_d   = '0;
    x_d        = '0;
    y_d        = '0;
    xdir_d     = '0;
    hit_cnt_d  = hit_count;
    xdir_pos_d = xdir_pos_q;
    hit_mask   = '0;
    n_hits     = '0;
    hit_sum    = '0;
    free_found = 1'b0;
    free_idx   = '0;
`ifdef BULLET_SCHED_LFSR_EN
    lfsr_d = frame_tick ? {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]} : lfsr_q;
`else
    x_idx_d = x_idx_q;
`endif

    if (!fight) begin
      fsm_d     = IDLE;
      slot_d    = '0;
      hit_cnt_d = '0;
    end else begin
      case (fsm_q)
        IDLE: begin
          fsm_d      = RUN;
          wave_cnt_d = '0;
          timer_d    = '0;
          hit_cnt_d  = '0;
          xdir_pos_d = 1'b0;
`ifndef BULLET_SCHED_LFSR_EN
          x_idx_d    = '0;
`endif
        end
        RUN, DRAIN: begin
          hit_mask = hit & slot_active;
          slot_d   = slot_active & ~hit_mask;
          for (int i = 0; i < NSLOT; i++) n_hits = n_hits + 3'(hit_mask[i]);
          hit_sum   = 5'(hit_count) + 5'(n_hits);
          hit_cnt_d = (hit_sum > 5'd15) ? 4'hF : hit_sum[3:0];

          if (frame_tick) begin
            for (int i = 0; i < NSLOT; i++) begin
              if (slot_active[i]) begin
                if (age_q[i] >= AW'(AGE_LAST)) slot_d[i] = 1'b0;
                else age_d[i] = age_q[i] + AW'(1);
              end
            end
          end

          if (fsm_q == RUN && frame_tick) begin
            wave_cnt_d = wave_cnt_q + WW'(1);
            timer_d    = (timer_q == TW'(SPAWN_INTERVAL - 1)) ? '0 : timer_q + TW'(1);
            if (timer_q == TW'(SPAWN_INTERVAL - 1)) begin
              // Descending scan so the lowest free index wins; freed-this-cycle slots are not free.
              for (int i = NSLOT - 1; i >= 0; i--) begin
                if (!slot_active[i]) begin
                  free_found = 1'b1;
                  free_idx   = 2'(i);
                end
              end
              if (free_found) begin
                slot_d[free_idx]   = 1'b1;
                age_d[free_idx]    = '0;
                strobe_d[free_idx] = 1'b1;
                y_d                = XW'(110);
                xdir_d             = xdir_pos_q ? 2'd2 : 2'd1;
                xdir_pos_d         = ~xdir_pos_q;
`ifdef BULLET_SCHED_LFSR_EN
                x_d                = XW'(136) + XW'(lfsr_d);
`else
                x_d                = XW'(160) + XW'(x_idx_q) * XW'(100);
                x_idx_d            = x_idx_q + 2'd1;
`endif
              end
            end
            if (wave_cnt_q == WW'(WAVE_FRAMES - 1)) fsm_d = DRAIN;
          end

          if (fsm_q == DRAIN && slot_active == '0) fsm_d = DONE;
        end
        DONE: fsm_d = DONE;
        default: fsm_d = IDLE;
      endcase
    end

    done_d = fight && (fsm_d == DONE);
  end

endmodule

// File: tb/tb_bullet_scheduler.sv
// Bench for bullet_scheduler: randomized and directed stimulus against a tick-count reference model.
module tb_bullet_scheduler;

  localparam int FIGHT = 1;
  localparam int SI    = 30;
  localparam int WF    = 600;
  localparam int LIFE  = 120;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] state;
  logic       frame_tick;
  logic [3:0] hit;
  logic [3:0] slot_active, spawn_strobe, hit_count;
  logic [9:0] spawn_x, spawn_y;
  logic [1:0] spawn_xdir;
  logic       wave_done;

  bullet_scheduler #(
    .FIGHT_STATE(FIGHT), .SPAWN_INTERVAL(SI), .WAVE_FRAMES(WF), .LIFE_FRAMES(LIFE)
  ) dut (
    .clk(clk), .reset(reset), .state(state), .frame_tick(frame_tick), .hit(hit),
    .slot_active(slot_active), .spawn_strobe(spawn_strobe), .spawn_x(spawn_x),
    .spawn_y(spawn_y), .spawn_xdir(spawn_xdir), .hit_count(hit_count), .wave_done(wave_done)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1 run, 2 drain, 3 done; ticks counted from RUN entry.
  int         m_phase, m_idx, m_hits, m_nspawn;
  int         m_born [4];
  logic [3:0] m_active, m_strobe;
  logic [9:0] m_x, m_y;
  logic [1:0] m_dir;
  logic       m_done;
  logic [7:0] m_lfsr;
  int         n_total = 0;
  int         n_pass  = 0;
  int         n_cycle = 0;

  function automatic void model_update(input logic r, input logic [3:0] st,
                                       input logic tk, input logic [3:0] h);
    logic [3:0] nxt;
    int cnt, old_phase;
    int life_end = (LIFE > 1) ? LIFE - 1 : 1;
    bit found = 0;
    if (r) begin
      m_phase = 0; m_idx = 0; m_hits = 0; m_nspawn = 0; m_active = '0; m_strobe = '0;
      m_x = '0; m_y = '0; m_dir = '0; m_done = 1'b0; m_lfsr = 8'hA5;
      return;
    end
    if (tk) m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    m_strobe = '0; m_x = '0; m_y = '0; m_dir = '0;
    if (st != 4'(FIGHT)) begin
      m_phase = 0; m_active = '0; m_hits = 0;
    end else if (m_phase == 0) begin
      m_phase = 1; m_idx = 0; m_hits = 0; m_nspawn = 0;
    end else if (m_phase == 1 || m_phase == 2) begin
      old_phase = m_phase;
      nxt = m_active & ~h;
      cnt = 0;
      for (int i = 0; i < 4; i++) if (h[i] && m_active[i]) cnt++;
      m_hits = (m_hits + cnt > 15) ? 15 : m_hits + cnt;
      if (tk) for (int i = 0; i < 4; i++)
        if (m_active[i] && (m_idx - m_born[i] == life_end)) nxt[i] = 1'b0;
      if (old_phase == 1 && tk) begin
        if (m_idx % SI == SI - 1) begin
          for (int i = 0; i < 4; i++) begin
            if (!found && !m_active[i]) begin
              found = 1;
              nxt[i] = 1'b1; m_born[i] = m_idx; m_strobe[i] = 1'b1;
              m_y = 10'd110;
              m_dir = (m_nspawn % 2 == 0) ? 2'd1 : 2'd2;
`ifdef BULLET_SCHED_LFSR_EN
              m_x = 10'(136 + int'(m_lfsr));
`else
              m_x = 10'(160 + 100 * (m_nspawn % 4));
`endif
              m_nspawn++;
            end
          end
        end
        if (m_idx == WF - 1) m_phase = 2;
      end
      if (old_phase == 2 && m_active == '0) m_phase = 3;
      if (tk) m_idx++;
      m_active = nxt;
    end
    m_done = (m_phase == 3);
  endfunction

  function automatic logic [34:0] obs_vec();
    return {slot_active, spawn_strobe, hit_count, wave_done,
            (m_strobe != 0) ? {spawn_x, spawn_y, spawn_xdir} : 22'd0};
  endfunction

  function automatic logic [34:0] exp_vec();
    return {m_active, m_strobe, 4'(m_hits), m_done,
            (m_strobe != 0) ? {m_x, m_y, m_dir} : 22'd0};
  endfunction

  task automatic step(input logic r, input logic [3:0] st, input logic tk, input logic [3:0] h);
    reset = r; state = st; frame_tick = tk; hit = h;
    model_update(r, st, tk, h);
    @(posedge clk);
    #1;
    n_cycle++;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 4'(FIGHT), 1'b1, 4'hF);
    n_total++; if (slot_active !== 4'h0) $display("FAIL reset slot_active: got %h expected 0", slot_active); else n_pass++;
    n_total++; if (spawn_strobe !== 4'h0) $display("FAIL reset spawn_strobe: got %h expected 0", spawn_strobe); else n_pass++;
    n_total++; if (spawn_x !== 10'd0 || spawn_y !== 10'd0) $display("FAIL reset spawn_xy: got %0d,%0d expected 0,0", spawn_x, spawn_y); else n_pass++;
    n_total++; if (spawn_xdir !== 2'd0) $display("FAIL reset spawn_xdir: got %0d expected 0", spawn_xdir); else n_pass++;
    n_total++; if (hit_count !== 4'd0) $display("FAIL reset hit_count: got %0d expected 0", hit_count); else n_pass++;
    n_total++; if (wave_done !== 1'b0) $display("FAIL reset wave_done: got %b expected 0", wave_done); else n_pass++;
  endtask

  task automatic test_first_spawn();
    step(1'b0, 4'(FIGHT), 1'b0, 4'h0);
    for (int t = 0; t < 30; t++) begin
      step(1'b0, 4'(FIGHT), 1'b1, 4'h0);
      n_total++; if (obs_vec() !== exp_vec()) $display("FAIL first_spawn tick %0d: got %h expected %h", t, obs_vec(), exp_vec()); else n_pass++;
      if (t != 29) step(1'b0, 4'(FIGHT), 1'b0, 4'h0);
    end
    n_total++; if (spawn_strobe !== 4'b0001) $display("FAIL first_strobe: got %b expected 0001", spawn_strobe); else n_pass++;
    n_total++; if (spawn_y !== 10'd110) $display("FAIL first_y: got %0d expected 110", spawn_y); else n_pass++;
    n_total++; if (spawn_xdir !== 2'd1) $display("FAIL first_xdir: got %0d expected 1", spawn_xdir); else n_pass++;
`ifndef BULLET_SCHED_LFSR_EN
    n_total++; if (spawn_x !== 10'd160) $display("FAIL first_x: got %0d expected 160", spawn_x); else n_pass++;
`endif
    step(1'b0, 4'(FIGHT), 1'b0, 4'h0);
    n_total++; if (spawn_strobe !== 4'b0000) $display("FAIL strobe_width: got %b expected 0000", spawn_strobe); else n_pass++;
  endtask

  task automatic test_fill_reuse();
    for (int t = 30; t < 150; t++) begin
      step(1'b0, 4'(FIGHT), 1'b1, 4'h0);
      n_total++; if (obs_vec() !== exp_vec()) $display("FAIL fill tick %0d: got %h expected %h", t, obs_vec(), exp_vec()); else n_pass++;
      if (t == 119) begin
        n_total++; if (slot_active !== 4'hF) $display("FAIL fill_all: got %b expected 1111", slot_active); else n_pass++;
      end
      if (t == 148) begin
        n_total++; if (slot_active !== 4'b1110) $display("FAIL expire_slot0: got %b expected 1110", slot_active); else n_pass++;
      end
      if (t == 149) begin
        n_total++; if (spawn_strobe !== 4'b0001) $display("FAIL reuse_slot0: got %b expected 0001", spawn_strobe); else n_pass++;
      end
    end
  endtask

  task automatic test_multi_hit();
    int guard = 0;
    step(1'b0, 4'(FIGHT), 1'b0, 4'b0011);
    n_total++; if (slot_active !== 4'b1100) $display("FAIL dual_hit_clear: got %b expected 1100", slot_active); else n_pass++;
    n_total++; if (hit_count !== 4'd2) $display("FAIL dual_hit_count: got %0d expected 2", hit_count); else n_pass++;
    while (m_hits < 15 && m_phase == 1 && guard < 1200) begin
      step(1'b0, 4'(FIGHT), 1'b1, 4'h0);
      step(1'b0, 4'(FIGHT), 1'b0, 4'hF);
      n_total++; if (obs_vec() !== exp_vec()) $display("FAIL sat_run cyc %0d: got %h expected %h", n_cycle, obs_vec(), exp_vec()); else n_pass++;
      guard++;
    end
    n_total++; if (hit_count !== 4'd15) $display("FAIL hit_saturate: got %0d expected 15", hit_count); else n_pass++;
    guard = 0;
    while (m_active == 4'h0 && m_phase == 1 && guard < 100) begin
      step(1'b0, 4'(FIGHT), 1'b1, 4'h0);
      guard++;
    end
    step(1'b0, 4'(FIGHT), 1'b0, 4'hF);
    n_total++; if (hit_count !== 4'd15) $display("FAIL hit_hold_15: got %0d expected 15", hit_count); else n_pass++;
  endtask

  task automatic test_drain_done();
    int guard = 0;
    int empty_cyc = -1;
    int done_cyc = -1;
    while (!m_done && guard < 3000) begin
      step(1'b0, 4'(FIGHT), 1'b1, ($urandom_range(7) == 0) ? 4'($urandom) : 4'h0);
      n_total++; if (obs_vec() !== exp_vec()) $display("FAIL drain cyc %0d: got %h expected %h", n_cycle, obs_vec(), exp_vec()); else n_pass++;
      if (m_phase >= 2 && slot_active == 4'h0 && empty_cyc < 0) empty_cyc = n_cycle;
      if (wave_done === 1'b1 && done_cyc < 0) done_cyc = n_cycle;
      guard++;
    end
    n_total++; if (wave_done !== 1'b1) $display("FAIL wave_done_timeout: got %b expected 1", wave_done); else n_pass++;
    n_total++; if (done_cyc - empty_cyc != 1) $display("FAIL done_latency: got %0d expected 1", done_cyc - empty_cyc); else n_pass++;
    for (int i = 0; i < 4; i++) step(1'b0, 4'(FIGHT), 1'b1, 4'hF);
    n_total++; if (wave_done !== 1'b1 || hit_count !== 4'd15) $display("FAIL done_hold: got done=%b hits=%0d expected done=1 hits=15", wave_done, hit_count); else n_pass++;
  endtask

  task automatic test_leave_fight();
    step(1'b0, 4'h0, 1'b0, 4'h0);
    n_total++; if (wave_done !== 1'b0 || hit_count !== 4'd0) $display("FAIL leave_done: got done=%b hits=%0d expected 0,0", wave_done, hit_count); else n_pass++;
    step(1'b0, 4'(FIGHT), 1'b0, 4'h0);
    for (int t = 0; t < 120; t++) begin
      step(1'b0, 4'(FIGHT), 1'b1, 4'h0);
      n_total++; if (obs_vec() !== exp_vec()) $display("FAIL leave_fill tick %0d: got %h expected %h", t, obs_vec(), exp_vec()); else n_pass++;
    end
    step(1'b0, 4'(FIGHT), 1'b0, 4'b1000);
    n_total++; if (slot_active !== 4'b0111 || hit_count !== 4'd1) $display("FAIL leave_setup: got %b/%0d expected 0111/1", slot_active, hit_count); else n_pass++;
    step(1'b0, 4'h0, 1'b1, 4'h0);
    n_total++; if (slot_active !== 4'h0 || hit_count !== 4'd0 || spawn_strobe !== 4'h0) $display("FAIL leave_clear: got %b/%0d/%b expected 0000/0/0000", slot_active, hit_count, spawn_strobe); else n_pass++;
    step(1'b0, 4'(FIGHT), 1'b0, 4'h0);
    n_total++; if (hit_count !== 4'd0) $display("FAIL reenter_hits: got %0d expected 0", hit_count); else n_pass++;
    for (int t = 0; t < 30; t++) step(1'b0, 4'(FIGHT), 1'b1, 4'h0);
    n_total++; if (spawn_strobe !== 4'b0001 || spawn_xdir !== 2'd1) $display("FAIL reenter_spawn: got %b/%0d expected 0001/1", spawn_strobe, spawn_xdir); else n_pass++;
  endtask

  task automatic test_reset_mid_wave();
    for (int t = 0; t < 40; t++) step(1'b0, 4'(FIGHT), 1'b1, 4'h0);
    step(1'b1, 4'(FIGHT), 1'b1, 4'hF);
    n_total++; if ({slot_active, spawn_strobe, spawn_x, spawn_y, spawn_xdir, hit_count, wave_done} !== 35'd0)
      $display("FAIL midwave_reset: got %h expected 0", {slot_active, spawn_strobe, spawn_x, spawn_y, spawn_xdir, hit_count, wave_done});
    else n_pass++;
    for (int t = 0; t < 40; t++) step(1'b0, 4'h0, 1'b1, 4'h0);
    n_total++; if (obs_vec() !== exp_vec() || slot_active !== 4'h0) $display("FAIL post_reset_idle: got %h expected %h", obs_vec(), exp_vec()); else n_pass++;
    step(1'b0, 4'(FIGHT), 1'b0, 4'h0);
    for (int t = 0; t < 30; t++) step(1'b0, 4'(FIGHT), 1'b1, 4'h0);
    n_total++; if (spawn_strobe !== 4'b0001) $display("FAIL post_reset_spawn: got %b expected 0001", spawn_strobe); else n_pass++;
  endtask

  task automatic test_random();
    logic r, tk;
    logic [3:0] st, h;
    for (int c = 0; c < 4000; c++) begin
      r  = ($urandom_range(799) == 0);
      st = ($urandom_range(299) == 0) ? 4'($urandom) : 4'(FIGHT);
      tk = ($urandom_range(1) == 0);
      h  = ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0;
      step(r, st, tk, h);
      n_total++; if (obs_vec() !== exp_vec()) $display("FAIL random cyc %0d: got %h expected %h", n_cycle, obs_vec(), exp_vec()); else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b1; state = 4'h0; frame_tick = 1'b0; hit = 4'h0;
    test_reset();
    test_first_spawn();
    test_fill_reuse();
    test_multi_hit();
    test_drain_done();
    test_leave_fight();
    test_reset_mid_wave();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
